// File: rtl/out_port_tx.sv
// OUT-port transmitter: 16-bit words are queued in a small FIFO and sent low byte first as
// two UART frames. Define OUT_PORT_TX_PARITY_EN to add an even-parity bit to each frame.
module out_port_tx #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic [4:0]  count,
    output logic        busy,
    output logic        overflow,
    output logic        tx
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef OUT_PORT_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          push, pop;

    state_t        state_q;
    logic [15:0]   shift_q;
    logic          byte_sel_q;
    logic [2:0]    bit_idx_q;
    logic [CW-1:0] cnt_q;
    logic          tx_q;
    logic [7:0]    cur_byte;
    logic          bit_end;

    // A pop frees no slot for a push in the same cycle: push only looks at registered full.
    always_comb begin
        push    = wr_en && !full_q;
        pop     = (state_q == S_IDLE) && !empty_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 5'd1;
        end else if (!push && pop) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == 5'(DEPTH));
            empty_q <= (count_d == 5'd0);
            if (wr_en && full_q) overflow_q <= 1'b1;
        end
    end

    assign cur_byte = byte_sel_q ? shift_q[15:8] : shift_q[7:0];
    assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // tx_q is loaded with the level of the state being entered, so it lines up with state_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            byte_sel_q <= 1'b0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (!empty_q) begin
                        shift_q    <= mem[rd_ptr_q];
                        byte_sel_q <= 1'b0;
                        state_q    <= S_START;
                        tx_q       <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= cur_byte[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef OUT_PORT_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= ^cur_byte;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= cur_byte[bit_idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef OUT_PORT_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (!byte_sel_q) begin
                            byte_sel_q <= 1'b1;
                            state_q    <= S_START;
                            tx_q       <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;
    assign tx       = tx_q;
endmodule
